// File: rtl/bpi_flash_wb_bridge.sv
// Read-only Wishbone classic slave fetching big-endian 32-bit words from 16-bit BPI flash.
// Optional one-entry last-word cache enabled by defining BPI_LAST_WORD_CACHE_EN.
module bpi_flash_wb_bridge #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [25:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [24:0] g18_adr_o,
    input  logic [15:0] g18_dat_i
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("bpi_flash_wb_bridge: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        RD_HI,
        RD_LO,
        RESP
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [23:0] w, w_d;
    logic [15:0] hi, hi_d;
    logic [31:0] dat_d;
    logic [24:0] adr_d;
    logic        ack_d, err_d;

    logic        req;
    logic [23:0] w_in;
    logic        hit;
    logic [31:0] hit_data;

    // Byte lanes and sub-word address bits play no role in a full-word read.
    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0]};

    assign req  = wb_cyc_i & wb_stb_i;
    assign w_in = wb_adr_i[25:2];

`ifdef BPI_LAST_WORD_CACHE_EN
    logic        c_valid, c_valid_d;
    logic [23:0] c_tag, c_tag_d;
    logic [31:0] c_data, c_data_d;

    assign hit      = c_valid && (c_tag == w_in);
    assign hit_data = c_data;
`else
    assign hit      = 1'b0;
    assign hit_data = 32'h0;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        w_d     = w;
        hi_d    = hi;
        dat_d   = wb_dat_o;
        adr_d   = g18_adr_o;
        ack_d   = 1'b0;
        err_d   = 1'b0;
`ifdef BPI_LAST_WORD_CACHE_EN
        c_valid_d = c_valid;
        c_tag_d   = c_tag;
        c_data_d  = c_data;
`endif
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (wb_we_i) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (hit) begin
                        dat_d   = hit_data;
                        ack_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        w_d     = w_in;
                        adr_d   = {w_in, 1'b0};
                        cnt_d   = WAIT_INIT;
                        state_d = RD_HI;
                    end
                end
            end
            RD_HI: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt == 4'd1) begin
                    hi_d    = g18_dat_i;
                    adr_d   = {w, 1'b1};
                    cnt_d   = WAIT_INIT;
                    state_d = RD_LO;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RD_LO: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt == 4'd1) begin
                    dat_d   = {hi, g18_dat_i};
                    ack_d   = 1'b1;
                    state_d = RESP;
`ifdef BPI_LAST_WORD_CACHE_EN
                    c_valid_d = 1'b1;
                    c_tag_d   = w;
                    c_data_d  = {hi, g18_dat_i};
`endif
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            w         <= 24'd0;
            hi        <= 16'd0;
            wb_dat_o  <= 32'd0;
            g18_adr_o <= 25'd0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            w         <= w_d;
            hi        <= hi_d;
            wb_dat_o  <= dat_d;
            g18_adr_o <= adr_d;
            wb_ack_o  <= ack_d;
            wb_err_o  <= err_d;
        end
    end

`ifdef BPI_LAST_WORD_CACHE_EN
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            c_valid <= 1'b0;
            c_tag   <= 24'd0;
            c_data  <= 32'd0;
        end else begin
            c_valid <= c_valid_d;
            c_tag   <= c_tag_d;
            c_data  <= c_data_d;
        end
    end
`endif

endmodule

// File: doc/bpi_flash_wb_bridge.md
# bpi_flash_wb_bridge

Read-only Wishbone classic slave inside `orpsoc` that fetches 32-bit words from the 16-bit BPI (G18) flash.
- Drives `g18_adr_o` and samples `g18_dat_i`, the flash port the bench flash model serves with one registered cycle of latency.
- Assembles two halfwords big-endian: the halfword at the even address is `[31:16]`.
- Serves instruction and data fetches of the boot and diag images: boot at byte 0x0, diag at byte 0x1000000.

## Interface
- `WAIT_CYCLES`, 2: cycles from address change to valid `g18_dat_i`; legal range 1..15.
- `sys_clk_i` in 1: the only clock.
- `sys_rst_i` in 1: reset, asynchronous and active-high.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: write enable; writes are rejected.
- `wb_adr_i` in 26: byte address; `[1:0]` is ignored.
- `wb_sel_i` in 4: ignored; the full word is always returned.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: read acknowledge, one-cycle pulse.
- `wb_err_o` out 1: write error, one-cycle pulse.
- `g18_adr_o` out 25: flash halfword address.
- `g18_dat_i` in 16: flash data.

## Operation
- Word index `w = wb_adr_i[25:2]`. Halfword addresses are `{w,1'b0}` (high half) and `{w,1'b1}` (low half).
- FSM states: IDLE, RD_HI, RD_LO, RESP.
- IDLE:
  - `cyc&stb&!we`: `g18_adr_o <= {w,0}`, `cnt <= WAIT_CYCLES`, go to RD_HI.
  - `cyc&stb&we`: `wb_err_o <= 1`, go to RESP.
- RD_HI: decrement `cnt` each edge. On the edge where `cnt==1`:
  - `hi <= g18_dat_i`, `g18_adr_o <= {w,1}`, `cnt <= WAIT_CYCLES`, go to RD_LO.
- RD_LO: decrement `cnt` each edge. On the edge where `cnt==1`:
  - `wb_dat_o <= {hi, g18_dat_i}`, `wb_ack_o <= 1`, go to RESP.
- RESP: clear ack/err, go to IDLE. New requests are never accepted in RESP, so a strobe still held in the ack cycle is not re-accepted.
- Abort: if `wb_cyc_i` is low on any edge in RD_HI or RD_LO, go to IDLE.
  - No ack, no data update, no cache update.
  - `g18_adr_o` holds its last value.
- `w` is latched at accept. Address changes by the master mid-transaction are ignored.
- `g18_adr_o` changes only on accept and on the HI→LO step, never in IDLE or RESP.
- Reset values: state IDLE; `wb_ack_o` 0, `wb_err_o` 0, `wb_dat_o` 0x00000000, `g18_adr_o` 0; `cnt` 0; `hi` 0; cache invalid.
- Async reset mid-read returns to IDLE immediately. No ack is issued for the interrupted request.

## Timing
- Accept happens on edge E0 (IDLE with valid strobe).
- Flash miss: `wb_ack_o` rises at edge E0+2·WAIT_CYCLES and is high for exactly one cycle. With the default this is 4 edges after accept.
- Write: `wb_err_o` is high for one cycle, starting at edge E0.
- Back-to-back reads: the next accept is possible at the edge after ack falls, so the minimum period is 2·WAIT_CYCLES+2 cycles.
- Each flash address is held stable for exactly WAIT_CYCLES cycles before its sample edge.
- `wb_ack_o` and `wb_err_o` are never asserted together.
- `cnt` is 4 bits. `WAIT_CYCLES` outside 1..15 is a configuration error, flagged by an elaboration-time `$error`.

## Configuration
- Macro `BPI_LAST_WORD_CACHE_EN`.
- Defined: a one-entry cache holds `valid`, a 24-bit `tag` and 32-bit data.
  - IDLE read with `valid && tag==w`: `wb_dat_o <= data`, `wb_ack_o <= 1`, go to RESP (ack at E0). No flash access and `g18_adr_o` unchanged.
  - A completed miss loads the cache with `tag <= w`, `valid <= 1`.
  - Writes and aborts leave the cache untouched.
  - Only reset invalidates, since the flash is read-only.
- Undefined: no cache registers; every read goes to flash with the miss timing.

## Test plan
- Read at byte 0x0, flash[0]=0x1234, flash[1]=0x5678, WAIT_CYCLES=2: `g18_adr_o` is 0 then 1; ack at E0+4 for one cycle; `wb_dat_o`=0x12345678.
- Read at byte 0x1000000, flash[0x800000]=0xDEAD, flash[0x800001]=0xBEEF: addresses 0x800000/0x800001; `wb_dat_o`=0xDEADBEEF. Stb held through ack produces no second ack.
- Write to byte 0x4: `wb_err_o` for one cycle at E0; no ack; `g18_adr_o` unchanged; `wb_dat_o` unchanged.
- Read at 0x8, `wb_cyc_i` dropped during RD_HI: no ack and no err; FSM in IDLE. A following read at 0x8 completes normally with correct data.
- Async reset asserted in RD_LO: all outputs at reset values within the same cycle; no ack after reset release.
- With `BPI_LAST_WORD_CACHE_EN`: read 0x0 twice. The first acks at E0+4; the second acks at E0 with 0x12345678 and no `g18_adr_o` activity. Then a read of 0x4 misses and fetches flash[2]/flash[3].
